// File: rtl/encode_pkg.sv
// Shared definitions for the encode block.
//   state_t     : packet FSM states
//   HDR_WORDS   : default count of leading words always passed in clear
//   LEN_THRESH  : default packet-length threshold above which the body is encrypted
//   KEY_IDX_W   : width of the key selector / key index
//   rotl8()     : 64-bit rotate-left by one byte, the final step of the cipher
package encode_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_KEY_REQ,
    S_KEY_WAIT,
    S_BODY,
    S_PASS
  } state_t;

  localparam int HDR_WORDS  = 11;
  localparam int LEN_THRESH = 100;
  localparam int KEY_IDX_W  = 14;

  function automatic logic [63:0] rotl8(input logic [63:0] x);
    return {x[55:0], x[63:56]};
  endfunction

endpackage

// File: rtl/encode_compute.sv
// Combinational word transform.
//   plain  : input word
//   key    : 64-bit key
//   enable : 1 -> cipher = rotl8(plain ^ key), 0 -> cipher = plain
//   cipher : transformed word
module encode_compute
  import encode_pkg::*;
(
  input  logic [63:0] plain,
  input  logic [63:0] key,
  input  logic        enable,
  output logic [63:0] cipher
);

  assign cipher = enable ? rotl8(plain ^ key) : plain;

endmodule

// File: rtl/encode.sv
// Packet encoder. Header words pass in clear; if the packet length field
// exceeds the threshold, a key is fetched over a simple read port and the
// remaining body words are encrypted. One-cycle latency, one word per cycle.
//   aclk, areset_n                     : clock, synchronous active-low reset
//   e_s_axi_data/valid/last/ready      : plaintext input stream
//   e_m_axi_data/valid/last/ready      : ciphertext output stream
//   e_axi_raddr, e_axi_rvalid          : key read address and one-cycle request pulse
//   e_axi_rd_rvalid/rd_last/rd_data    : key read response beats
module encode
  import encode_pkg::*;
#(
  parameter int C_AXI_ADDR_WIDTH = 32,
  parameter int C_AXI_DATA_WIDTH = 512,
  parameter int HDR_WORDS        = encode_pkg::HDR_WORDS,
  parameter int LEN_THRESH       = encode_pkg::LEN_THRESH
) (
  input  logic                        aclk,
  input  logic                        areset_n,
  input  logic [63:0]                 e_s_axi_data,
  input  logic                        e_s_axi_valid,
  input  logic                        e_s_axi_last,
  output logic                        e_s_axi_ready,
  output logic [63:0]                 e_m_axi_data,
  output logic                        e_m_axi_valid,
  output logic                        e_m_axi_last,
  input  logic                        e_m_axi_ready,
  output logic [C_AXI_ADDR_WIDTH-1:0] e_axi_raddr,
  output logic                        e_axi_rvalid,
  input  logic                        e_axi_rd_rvalid,
  input  logic                        e_axi_rd_last,
  input  logic [C_AXI_DATA_WIDTH-1:0] e_axi_rd_data
);

  localparam logic [15:0] HDR_LAST  = 16'(HDR_WORDS - 1);
  localparam logic [15:0] LEN_LIMIT = 16'(LEN_THRESH);
  localparam logic [15:0] IDX_MAX   = 16'hFFFF;

  state_t                 state;
  logic [15:0]            word_idx;
  logic [15:0]            p_len;
  logic [KEY_IDX_W-1:0]   key_sel;
  logic [KEY_IDX_W-1:0]   next_sel;
  logic [63:0]            key;
  logic                   key_got;
  logic                   can_flow;
  logic                   accept;
  logic [63:0]            cipher;

  // Only the low 64 bits of the key response carry the key.
  logic unused_rd_bits;
  assign unused_rd_bits = ^e_axi_rd_data[C_AXI_DATA_WIDTH-1:64];

  // NOTE: every variable gets a default before any branch so no latch is inferred.
  always_comb begin
    can_flow = 1'b0;
    if (state inside {S_IDLE, S_HDR, S_BODY, S_PASS}) can_flow = 1'b1;
  end

  // Output register can take a new word when empty or draining this cycle.
  assign e_s_axi_ready = areset_n && can_flow && (!e_m_axi_valid || e_m_axi_ready);
  assign accept        = e_s_axi_valid && e_s_axi_ready;

  // Selector as it will be once word 10 is folded in; used to form the
  // address in the same cycle the key request is launched.
  assign next_sel = key_sel ^ e_s_axi_data[KEY_IDX_W-1:0];

  encode_compute u_compute (
    .plain  (e_s_axi_data),
    .key    (key),
    .enable (state == S_BODY),
    .cipher (cipher)
  );

  // NOTE: reset is sampled synchronously here and all state uses non-blocking
  // assignments so every register updates from pre-edge values.
  always_ff @(posedge aclk) begin
    if (!areset_n) begin
      state         <= S_IDLE;
      word_idx      <= '0;
      p_len         <= '0;
      key_sel       <= '0;
      key           <= '0;
      key_got       <= 1'b0;
      e_m_axi_data  <= '0;
      e_m_axi_valid <= 1'b0;
      e_m_axi_last  <= 1'b0;
      e_axi_rvalid  <= 1'b0;
      e_axi_raddr   <= '0;
    end else begin
      e_axi_rvalid <= 1'b0;

      // Output register: load on accept, otherwise drain when taken.
      if (accept) begin
        e_m_axi_data  <= cipher;
        e_m_axi_last  <= e_s_axi_last;
        e_m_axi_valid <= 1'b1;
      end else if (e_m_axi_ready) begin
        e_m_axi_valid <= 1'b0;
      end

      // Word index and header field capture.
      if (accept) begin
        if (e_s_axi_last)         word_idx <= '0;
        else if (word_idx != IDX_MAX) word_idx <= word_idx + 16'd1;

        if (word_idx == 16'd2)  p_len   <= {e_s_axi_data[7:0], e_s_axi_data[15:8]};
        if (word_idx == 16'd9)  key_sel <= e_s_axi_data[KEY_IDX_W-1:0];
        if (word_idx == 16'd10) key_sel <= next_sel;
      end

      unique case (state)
        S_IDLE, S_HDR: begin
          if (accept) begin
            if (e_s_axi_last) begin
              state <= S_IDLE;
            end else if (word_idx == HDR_LAST) begin
              if (p_len > LEN_LIMIT) begin
                state        <= S_KEY_REQ;
                e_axi_rvalid <= 1'b1;
                e_axi_raddr  <= C_AXI_ADDR_WIDTH'({next_sel, 6'b0});
              end else begin
                state <= S_PASS;
              end
            end else begin
              state <= S_HDR;
            end
          end
        end

        // Request pulse was raised on entry; it drops as we leave.
        S_KEY_REQ: state <= S_KEY_WAIT;

        S_KEY_WAIT: begin
          if (e_axi_rd_rvalid) begin
            if (!key_got) begin
              key     <= e_axi_rd_data[63:0];
              key_got <= 1'b1;
            end
            if (e_axi_rd_last) begin
              key_got <= 1'b0;
              state   <= S_BODY;
            end
          end
        end

        S_BODY, S_PASS: begin
          if (accept && e_s_axi_last) state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_encode.sv
// Self-checking bench for encode: directed scenarios plus randomized packets,
// compared against a packet-level reference model.
module tb_encode;

  localparam int AW     = 32;
  localparam int DW     = 512;
  localparam int HDR    = 11;
  localparam int THRESH = 100;

  logic          aclk = 1'b0;
  logic          areset_n;
  logic [63:0]   e_s_axi_data;
  logic          e_s_axi_valid;
  logic          e_s_axi_last;
  logic          e_s_axi_ready;
  logic [63:0]   e_m_axi_data;
  logic          e_m_axi_valid;
  logic          e_m_axi_last;
  logic          e_m_axi_ready;
  logic [AW-1:0] e_axi_raddr;
  logic          e_axi_rvalid;
  logic          e_axi_rd_rvalid;
  logic          e_axi_rd_last;
  logic [DW-1:0] e_axi_rd_data;

  always #5 aclk = ~aclk;

  encode #(
    .C_AXI_ADDR_WIDTH (AW),
    .C_AXI_DATA_WIDTH (DW),
    .HDR_WORDS        (HDR),
    .LEN_THRESH       (THRESH)
  ) dut (
    .aclk            (aclk),
    .areset_n        (areset_n),
    .e_s_axi_data    (e_s_axi_data),
    .e_s_axi_valid   (e_s_axi_valid),
    .e_s_axi_last    (e_s_axi_last),
    .e_s_axi_ready   (e_s_axi_ready),
    .e_m_axi_data    (e_m_axi_data),
    .e_m_axi_valid   (e_m_axi_valid),
    .e_m_axi_last    (e_m_axi_last),
    .e_m_axi_ready   (e_m_axi_ready),
    .e_axi_raddr     (e_axi_raddr),
    .e_axi_rvalid    (e_axi_rvalid),
    .e_axi_rd_rvalid (e_axi_rd_rvalid),
    .e_axi_rd_last   (e_axi_rd_last),
    .e_axi_rd_data   (e_axi_rd_data)
  );

  int tests = 0;
  int fails = 0;

  logic [63:0] pkt[$];
  logic [15:0] cur_plen;
  logic [64:0] exp_q[$];
  logic [64:0] got_q[$];
  logic [31:0] exp_raddr_q[$];
  logic [31:0] got_raddr_q[$];
  logic [63:0] key_q[$];

  int ready_mode = 0;
  bit resp_en    = 1'b1;
  int stray_req  = 0;

  task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_rotl(input logic [63:0] x);
    return (x << 8) | (x >> 56);
  endfunction

  // Output ready pattern.
  initial begin
    e_m_axi_ready = 1'b1;
    forever begin
      @(posedge aclk); #1;
      case (ready_mode)
        0:       e_m_axi_ready = 1'b1;
        1:       e_m_axi_ready = ~e_m_axi_ready;
        default: e_m_axi_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Key memory: answers each request with 1..3 beats, key in the first beat.
  initial begin
    logic [63:0] k;
    int nb;
    int stray_done;
    stray_done      = 0;
    e_axi_rd_rvalid = 1'b0;
    e_axi_rd_last   = 1'b0;
    e_axi_rd_data   = '0;
    forever begin
      @(negedge aclk);
      if (stray_req != stray_done) begin
        stray_done = stray_req;
        @(posedge aclk); #1;
        repeat (2) begin
          e_axi_rd_rvalid = 1'b1;
          e_axi_rd_last   = 1'b1;
          for (int j = 0; j < DW / 32; j++) e_axi_rd_data[j*32 +: 32] = $urandom;
          @(posedge aclk); #1;
        end
        e_axi_rd_rvalid = 1'b0;
        e_axi_rd_last   = 1'b0;
      end else if (e_axi_rvalid && resp_en) begin
        k  = (key_q.size() > 0) ? key_q.pop_front() : 64'd0;
        nb = $urandom_range(1, 3);
        @(posedge aclk); #1;
        repeat ($urandom_range(0, 2)) begin @(posedge aclk); #1; end
        for (int b = 0; b < nb; b++) begin
          for (int j = 0; j < DW / 32; j++) e_axi_rd_data[j*32 +: 32] = $urandom;
          if (b == 0) e_axi_rd_data[63:0] = k;
          e_axi_rd_last   = (b == nb - 1);
          e_axi_rd_rvalid = 1'b1;
          @(posedge aclk); #1;
        end
        e_axi_rd_rvalid = 1'b0;
        e_axi_rd_last   = 1'b0;
      end
    end
  end

  // Output / request monitor, sampled on the falling edge.
  logic        hold_pend = 1'b0;
  logic [64:0] hold_val;
  always @(negedge aclk) begin
    if (!areset_n) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        check("hold_valid", 65'(e_m_axi_valid), 65'(1));
        check("hold_beat", {e_m_axi_last, e_m_axi_data}, hold_val);
      end
      if (e_m_axi_valid && e_m_axi_ready) got_q.push_back({e_m_axi_last, e_m_axi_data});
      if (e_axi_rvalid) got_raddr_q.push_back(e_axi_raddr);
      hold_pend = e_m_axi_valid && !e_m_axi_ready;
      hold_val  = {e_m_axi_last, e_m_axi_data};
    end
  end

  task automatic make_packet(input int n, input logic [15:0] pl,
                             input logic [13:0] w9, input logic [13:0] w10);
    logic [63:0] w;
    pkt.delete();
    for (int i = 0; i < n; i++) begin
      w = {$urandom, $urandom};
      if (i == 2)  w[15:0] = {pl[7:0], pl[15:8]};
      if (i == 9)  w[13:0] = w9;
      if (i == 10) w[13:0] = w10;
      pkt.push_back(w);
    end
    cur_plen = pl;
  endtask

  // Reference model: header words clear; body encrypted only when the packet
  // runs past the header and its length field exceeds the threshold.
  task automatic queue_expect(input int n, input logic [63:0] key);
    bit          enc;
    logic [63:0] w9, w10;
    enc = (n > HDR) && (int'(cur_plen) > THRESH);
    for (int i = 0; i < n; i++)
      exp_q.push_back({(i == n - 1), (enc && i >= HDR) ? ref_rotl(pkt[i] ^ key) : pkt[i]});
    if (enc) begin
      w9  = pkt[9];
      w10 = pkt[10];
      exp_raddr_q.push_back(32'((w9 & 64'h3FFF) ^ (w10 & 64'h3FFF)) * 32'd64);
      key_q.push_back(key);
    end
  endtask

  task automatic send_packet(input int n, input bit with_last, output int cycles);
    int i;
    bit acc;
    i      = 0;
    cycles = 0;
    while (i < n && cycles < 2000) begin
      e_s_axi_valid = 1'b1;
      e_s_axi_data  = pkt[i];
      e_s_axi_last  = with_last && (i == n - 1);
      @(negedge aclk);
      acc = e_s_axi_ready;
      @(posedge aclk); #1;
      if (acc) i++;
      cycles++;
    end
    e_s_axi_valid = 1'b0;
    e_s_axi_last  = 1'b0;
    if (i < n) check("send_timeout", 65'(i), 65'(n));
  endtask

  task automatic wait_drain();
    int c;
    c = 0;
    while (got_q.size() < exp_q.size() && c < 3000) begin
      @(posedge aclk);
      c++;
    end
    repeat (6) @(posedge aclk);
    #1;
  endtask

  task automatic compare_all(input string tag);
    check({tag, "_beats"}, 65'(got_q.size()), 65'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s_beat%0d", tag, i), got_q[i], exp_q[i]);
    check({tag, "_reqs"}, 65'(got_raddr_q.size()), 65'(exp_raddr_q.size()));
    for (int i = 0; i < exp_raddr_q.size() && i < got_raddr_q.size(); i++)
      check($sformatf("%s_raddr%0d", tag, i), 65'(got_raddr_q[i]), 65'(exp_raddr_q[i]));
    got_q.delete();
    exp_q.delete();
    got_raddr_q.delete();
    exp_raddr_q.delete();
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_m_valid"}, 65'(e_m_axi_valid), 65'(0));
    check({tag, "_m_last"},  65'(e_m_axi_last),  65'(0));
    check({tag, "_m_data"},  65'(e_m_axi_data),  65'(0));
    check({tag, "_rvalid"},  65'(e_axi_rvalid),  65'(0));
    check({tag, "_raddr"},   65'(e_axi_raddr),   65'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          cyc;
    int          n;
    logic [15:0] pl;
    logic [63:0] k;

    areset_n      = 1'b0;
    e_s_axi_valid = 1'b0;
    e_s_axi_last  = 1'b0;
    e_s_axi_data  = '0;

    // Reset state.
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check("rst_s_ready", 65'(e_s_axi_ready), 65'(0));
    check_idle_outputs("rst");
    @(posedge aclk); #1;
    areset_n = 1'b1;
    @(negedge aclk);
    check("idle_s_ready", 65'(e_s_axi_ready), 65'(1));
    @(posedge aclk); #1;

    // Encrypted packet, zero key, selector 3^1 -> address 0x80, word 11 0xFF -> 0xFF00.
    make_packet(14, 16'd200, 14'h0003, 14'h0001);
    pkt[11] = 64'h0000_0000_0000_00FF;
    queue_expect(14, 64'd0);
    send_packet(14, 1'b1, cyc);
    wait_drain();
    check("zero_key_w11", (got_q.size() > 11) ? got_q[11] : 65'h0, {1'b0, 64'h0000_0000_0000_FF00});
    check("zero_key_raddr", (got_raddr_q.size() > 0) ? 65'(got_raddr_q[0]) : 65'h0, 65'h80);
    compare_all("zero_key");

    // Length exactly at threshold stays clear, one word per cycle.
    make_packet(14, 16'd100, 14'($urandom), 14'($urandom));
    queue_expect(14, 64'd0);
    send_packet(14, 1'b1, cyc);
    check("at_thresh_cycles", 65'(cyc), 65'(14));
    wait_drain();
    compare_all("at_thresh");

    // Short packet with a large length field: no key read.
    make_packet(8, 16'd300, 14'($urandom), 14'($urandom));
    queue_expect(8, 64'd0);
    send_packet(8, 1'b1, cyc);
    wait_drain();
    compare_all("short");

    // Encrypted packet with output back-pressure toggling every cycle.
    ready_mode = 1;
    make_packet(20, 16'd500, 14'($urandom), 14'($urandom));
    queue_expect(20, {$urandom, $urandom});
    send_packet(20, 1'b1, cyc);
    wait_drain();
    compare_all("toggle");
    ready_mode = 0;

    // Back-to-back: encrypted packet then a clear one; index and length recaptured.
    make_packet(12, 16'd300, 14'($urandom), 14'($urandom));
    queue_expect(12, {$urandom, $urandom});
    send_packet(12, 1'b1, cyc);
    make_packet(14, 16'd50, 14'($urandom), 14'($urandom));
    queue_expect(14, 64'd0);
    send_packet(14, 1'b1, cyc);
    check("b2b_second_cycles", 65'(cyc), 65'(14));
    wait_drain();
    compare_all("b2b");

    // Reset while waiting for the key, then stray response beats.
    resp_en = 1'b0;
    make_packet(20, 16'd250, 14'($urandom), 14'($urandom));
    for (int i = 0; i < HDR; i++) exp_q.push_back({1'b0, pkt[i]});
    k = pkt[9] ^ pkt[10];
    exp_raddr_q.push_back(32'(k & 64'h3FFF) * 32'd64);
    send_packet(HDR, 1'b0, cyc);
    wait_drain();
    compare_all("abort_hdr");
    @(negedge aclk);
    check("key_wait_s_ready", 65'(e_s_axi_ready), 65'(0));
    @(posedge aclk); #1;
    areset_n = 1'b0;
    @(negedge aclk);
    check("abort_rst_s_ready", 65'(e_s_axi_ready), 65'(0));
    @(posedge aclk); #1;
    areset_n = 1'b1;
    @(negedge aclk);
    check_idle_outputs("abort");
    stray_req++;
    repeat (5) @(posedge aclk);
    @(negedge aclk);
    check("stray_s_ready", 65'(e_s_axi_ready), 65'(1));
    check("stray_reqs", 65'(got_raddr_q.size()), 65'(0));
    check("stray_beats", 65'(got_q.size()), 65'(0));
    @(posedge aclk); #1;
    resp_en = 1'b1;
    make_packet(13, 16'd120, 14'($urandom), 14'($urandom));
    queue_expect(13, {$urandom, $urandom});
    send_packet(13, 1'b1, cyc);
    wait_drain();
    compare_all("after_abort");

    // Randomized packets with random back-pressure.
    ready_mode = 2;
    for (int t = 0; t < 8; t++) begin
      n = $urandom_range(1, 24);
      case ($urandom_range(0, 2))
        0:       pl = 16'd100;
        1:       pl = 16'd101;
        default: pl = 16'($urandom);
      endcase
      make_packet(n, pl, 14'($urandom), 14'($urandom));
      queue_expect(n, {$urandom, $urandom});
      send_packet(n, 1'b1, cyc);
      wait_drain();
      compare_all($sformatf("rand%0d", t));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/encode.md
ENCODE -- requirements
Module: encode

Interface
REQ-001 SHALL have parameter C_AXI_ADDR_WIDTH, default 32, key read address width.
REQ-002 SHALL have parameter C_AXI_DATA_WIDTH, default 512, key read data width.
REQ-003 SHALL have parameter HDR_WORDS, default 11, count of leading words always passed in clear.
REQ-004 SHALL have parameter LEN_THRESH, default 100, packet-length threshold for encryption.
REQ-005 aclk  in  1  sole clock; all logic on rising edge.
REQ-006 areset_n  in  1  reset, synchronous, active-low.
REQ-007 e_s_axi_data/valid/last  in  64/1/1  plaintext input stream; e_s_axi_ready  out  1.
REQ-008 e_m_axi_data/valid/last  out  64/1/1  ciphertext output stream; e_m_axi_ready  in  1.
REQ-009 e_axi_raddr  out  C_AXI_ADDR_WIDTH  key read address; e_axi_rvalid  out  1  address valid pulse.
REQ-010 e_axi_rd_rvalid/e_axi_rd_last  in  1/1; e_axi_rd_data  in  C_AXI_DATA_WIDTH  key read response.

Function
REQ-011 Input words SHALL be indexed 0.. per packet; index resets to 0 after the beat carrying last.
REQ-012 p_len SHALL be {data[7:0],data[15:8]} of word 2, captured on its handshake.
REQ-013 Words 9 and 10 SHALL be captured as key selector; key_idx = w9[13:0] XOR w10[13:0].
REQ-014 FSM states SHALL be IDLE, HDR, KEY_REQ, KEY_WAIT, BODY, PASS.
REQ-015 IDLE->HDR on first input valid; HDR passes words 0..10 unchanged.
REQ-016 On acceptance of word 10 with last=0: p_len>LEN_THRESH -> KEY_REQ, else -> PASS.
REQ-017 Any accepted beat with last=1 SHALL return FSM to IDLE after its output is loaded, regardless of state.
REQ-018 KEY_REQ SHALL assert e_axi_rvalid for exactly one cycle with e_axi_raddr = {12'b0, key_idx, 6'b0}, then go KEY_WAIT.
REQ-019 KEY_WAIT SHALL latch key = e_axi_rd_data[63:0] on first rd_rvalid beat, ignore further beats up to rd_last, then go BODY.
REQ-020 rd_rvalid outside KEY_WAIT SHALL be ignored; no key state change.
REQ-021 BODY output word = rotl8(plain XOR key); PASS/HDR output word = plain.
REQ-022 e_s_axi_ready SHALL be 1 only in HDR/BODY/PASS (or IDLE) and when output register empty or e_m_axi_ready=1; 0 in KEY_REQ/KEY_WAIT.
REQ-023 Latency SHALL be 1 cycle: accepted beat appears on e_m_axi_* next cycle; last copied through.
REQ-024 e_m_axi_valid SHALL hold, with data/last stable, until e_m_axi_ready=1; no beat dropped or duplicated.
REQ-025 Sustained throughput SHALL be one word/cycle in HDR/BODY/PASS with e_m_axi_ready=1.
REQ-026 p_len exactly LEN_THRESH SHALL be treated as clear (PASS).
REQ-027 Packet shorter than 11 words SHALL never issue a key read.
REQ-028 Word-index counter SHALL saturate at 16'hFFFF without wrap; BODY continues encrypting.

Reset
REQ-029 areset_n=0 at a clock edge SHALL force IDLE, clear index, p_len, key, selector, output register.
REQ-030 During/after reset: e_s_axi_ready=0 while areset_n=0, e_m_axi_valid=0, e_m_axi_last=0, e_m_axi_data=0, e_axi_rvalid=0, e_axi_raddr=0.
REQ-031 Reset mid-packet or mid-key-fetch SHALL abandon packet; late rd_rvalid beats after reset SHALL be ignored.

Structure
REQ-032 Shared package encode_pkg SHALL hold FSM state enum, HDR_WORDS, LEN_THRESH, rotl8 function, key-index width 14.
REQ-033 One sub-module encode_compute (combinational, plain+key+enable -> cipher) SHALL be instantiated; FSM and counters stay in encode.

Verification
REQ-034 p_len=200, 14 words, w9=0x0003, w10=0x0001, key=0 -> raddr=0x80, words 0-10 clear, word 11 plain 0xFF -> 0xFF00.
REQ-035 p_len=100, 14 words -> no e_axi_rvalid, all 14 output words equal input.
REQ-036 p_len=300, 8-word packet -> no key read, 8 words out unchanged, last on word 7.
REQ-037 e_m_axi_ready toggled 1/0 each cycle, 20-word encrypted packet -> 20 beats, order and data correct, none lost.
REQ-038 areset_n low 1 cycle while in KEY_WAIT, then stray rd_rvalid -> IDLE, outputs 0, next packet processed correctly.
REQ-039 Back-to-back packets, last then valid next cycle -> second packet word 0 indexed 0, p_len recaptured.
